// File: rtl/ad9122_spi_pkg.sv
// Shared types and constants for the AD9122 SPI transaction engine.
// Optional feature macro: AD9122_SPI_4WIRE_EN (see ad9122_spi_master).
package ad9122_spi_pkg;

    // One-hot transaction states
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_SETUP = 5'b00010,
        ST_SHIFT = 5'b00100,
        ST_HOLD  = 5'b01000,
        ST_GAP   = 5'b10000
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 7;
    localparam int DATA_BITS  = 8;

    // Assemble the on-wire frame: R/W flag, 7-bit address, data byte
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rd,
        input logic [RW_BIT-1:0]    addr,
        input logic [DATA_BITS-1:0] data
    );
        return {rd, addr, data};
    endfunction

endpackage

// File: rtl/ad9122_spi_sclk_gen.sv
// SCLK generator: CLK_DIV clk cycles low then CLK_DIV clk cycles high per bit.
// rise_stb/fall_stb are high in the clk cycle whose closing edge moves SCLK.
module ad9122_spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);
    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            sclk_q, sclk_d;

    // Phase counting and SCLK edge decisions; counter parks at zero when disabled
    always_comb begin
        rise_stb = en && (phase_q == PH_RISE);
        fall_stb = en && (phase_q == PH_LAST);
        phase_d  = phase_q;
        sclk_d   = sclk_q;
        if (!en || fall_stb) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
        if (rise_stb) begin
            sclk_d = 1'b1;
        end else if (fall_stb || !en) begin
            sclk_d = 1'b0;
        end
    end

    // Phase and SCLK registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q <= '0;
            sclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/ad9122_spi_master.sv
// AD9122 3-wire SPI master: one 16-bit register access per request.
// Define AD9122_SPI_4WIRE_EN to read from the separate SDO pin and keep SDIO
// driven for the whole frame.
module ad9122_spi_master
    import ad9122_spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int CSN_SETUP = 2,
    parameter int CSN_HOLD  = 2,
    parameter int CSN_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       write_req,
    input  logic       read_req,
    input  logic [7:0] ad_rw_addr,
    input  logic [7:0] w_ad_data,
    output logic       r_w_end,
    output logic [7:0] r_ad_data,
    output logic       busy,
    output logic       spi_csn,
    output logic       spi_sclk,
    output logic       spi_sdio_o,
    output logic       spi_sdio_oe,
    input  logic       spi_sdio_i,
    input  logic       spi_sdo_i
);
    localparam int CNT_MAX = (CSN_SETUP > CSN_HOLD)
                           ? ((CSN_SETUP > CSN_IDLE) ? CSN_SETUP : CSN_IDLE)
                           : ((CSN_HOLD > CSN_IDLE) ? CSN_HOLD : CSN_IDLE);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [FRAME_BITS-1:0]  sh_q, sh_d;
    logic                   rw_q, rw_d;
    logic                   csn_q, csn_d;
    logic                   oe_q, oe_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic [DATA_BITS-1:0]   rd_sh_q, rd_sh_d;
    logic                   sdi;
    logic                   oe_drop;
    logic                   rise_stb, fall_stb;
    logic [1:0]             unused_in;

`ifdef AD9122_SPI_4WIRE_EN
    assign sdi       = spi_sdo_i;
    assign oe_drop   = 1'b0;
    assign unused_in = {spi_sdio_i, ad_rw_addr[RW_BIT]};
`else
    assign sdi       = spi_sdio_i;
    assign oe_drop   = 1'b1;
    assign unused_in = {spi_sdo_i, ad_rw_addr[RW_BIT]};
`endif

    ad9122_spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk      (clk),
        .rstn     (rstn),
        .en       (state_q == ST_SHIFT),
        .sclk     (spi_sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Frame sequencing: next state, pin controls, shift and capture registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rw_d    = rw_q;
        csn_d   = csn_q;
        oe_d    = oe_q;
        rdata_d = rdata_q;
        rd_sh_d = rd_sh_q;
        unique case (state_q)
            ST_IDLE: begin
                // A simultaneous read request loses to the write
                if (write_req || read_req) begin
                    rw_d    = !write_req;
                    sh_d    = build_frame(!write_req, ad_rw_addr[RW_BIT-1:0], w_ad_data);
                    bit_d   = 4'd15;
                    cnt_d   = CNT_W'(CSN_SETUP - 1);
                    csn_d   = 1'b0;
                    oe_d    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (rise_stb && rw_q && (bit_q <= 4'd7)) begin
                    rd_sh_d = {rd_sh_q[DATA_BITS-2:0], sdi};
                end
                if (fall_stb) begin
                    if (bit_q == 4'd0) begin
                        cnt_d   = CNT_W'(CSN_HOLD - 1);
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q - 1'b1;
                        sh_d  = {sh_q[FRAME_BITS-2:0], 1'b0};
                        // Turn the bus around before the DAC drives the first data bit
                        if (oe_drop && rw_q && (bit_q == 4'd8)) begin
                            oe_d = 1'b0;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    csn_d   = 1'b1;
                    oe_d    = 1'b0;
                    if (rw_q) begin
                        rdata_d = rd_sh_q;
                    end
                    cnt_d   = CNT_W'(CSN_IDLE - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                csn_d   = 1'b1;
                oe_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rw_q    <= 1'b0;
            csn_q   <= 1'b1;
            oe_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rw_q    <= rw_d;
            csn_q   <= csn_d;
            oe_q    <= oe_d;
            rdata_q <= rdata_d;
        end
    end

    // Read-data assembly register; only published through rdata_q
    always_ff @(posedge clk) begin
        rd_sh_q <= rd_sh_d;
    end

    assign r_w_end     = (state_q == ST_GAP) && (cnt_q == '0);
    assign busy        = (state_q != ST_IDLE);
    assign spi_csn     = csn_q;
    assign spi_sdio_o  = sh_q[FRAME_BITS-1];
    assign spi_sdio_oe = oe_q;
    assign r_ad_data   = rdata_q;

endmodule

// File: doc/ad9122_spi_master.md
Name: ad9122_spi_master

Overview:
- SPI transaction engine that executes single register accesses requested by the AD9122 register-configuration sequencer.
- Converts one write_req/read_req strobe plus address/data bytes into a 16-bit AD9122 3-wire SPI frame: 8-bit instruction (R/W, A6..A0), then 8 data bits, MSB first.
- Returns a one-cycle r_w_end completion pulse and, for reads, the captured byte.
- Sits between the config sequencer and the DAC SPI pins.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 1.
- CSN_SETUP, 2, clk cycles from CSN falling to first SCLK low phase start; >= 1.
- CSN_HOLD, 2, clk cycles from last SCLK falling edge to CSN rising; >= 1.
- CSN_IDLE, 4, clk cycles CSN held high before r_w_end; >= 1.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- write_req  in  1  single-cycle write request strobe
- read_req  in  1  single-cycle read request strobe
- ad_rw_addr  in  8  instruction byte; only bits [6:0] are used
- w_ad_data  in  8  write data
- r_w_end  out  1  one-cycle transaction-complete pulse
- r_ad_data  out  8  last read byte
- busy  out  1  high from request acceptance until the cycle after r_w_end
- spi_csn  out  1  chip select, active-low
- spi_sclk  out  1  SPI clock; idles low (CPOL=0)
- spi_sdio_o  out  1  SDIO output data
- spi_sdio_oe  out  1  SDIO output enable; 1 = drive
- spi_sdio_i  in  1  SDIO input data from pad
- spi_sdo_i  in  1  separate SDO pin; used only with the optional feature

Behaviour:
- Reset values: spi_csn=1, spi_sclk=0, spi_sdio_o=0, spi_sdio_oe=0, r_w_end=0, r_ad_data=0x00, busy=0, state=IDLE.
- Reset is synchronous. Asserting it mid-transaction aborts the frame: CSN returns high on the next edge and no r_w_end is generated.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - Requests are sampled only in IDLE. Requests in any other state are ignored (no queueing).
  - write_req and read_req together: the write is performed and the read is dropped.
  - On acceptance:
    - Latch the shift register as {rw, ad_rw_addr[6:0], w_ad_data}, with rw=1 for read and rw=0 for write. ad_rw_addr[7] is ignored.
    - Drive spi_csn=0, spi_sdio_oe=1 and busy=1, then go to SETUP.
- SETUP: lasts CSN_SETUP cycles. spi_sdio_o presents bit 15.
- SHIFT: 16 bits, each bit CLK_DIV cycles with SCLK low followed by CLK_DIV cycles with SCLK high.
  - spi_sdio_o changes only at the start of a low phase.
  - The DAC samples on the SCLK rising edge.
  - Read only: at the start of the low phase of bit index 7 (the first data bit), spi_sdio_oe drops to 0.
  - Read only: spi_sdio_i is sampled on the clk edge that raises SCLK for bits 7..0 and shifted into r_ad_data MSB first.
  - r_ad_data updates only when the read frame completes; a write leaves it unchanged.
- HOLD: SCLK low for CSN_HOLD cycles, then spi_csn=1 and spi_sdio_oe=0.
- GAP: lasts CSN_IDLE cycles. r_w_end=1 in the last GAP cycle; next edge goes to IDLE and busy=0.
- Latency: taking the accepting edge as cycle 1, r_w_end is high in cycle CSN_SETUP + 32*CLK_DIV + CSN_HOLD + CSN_IDLE. With defaults this is cycle 136.
- The sequencer's request issued the cycle after r_w_end must be accepted (zero dead cycles).
- Counters: bit counter is 4 bits and counts 15 down to 0; phase counter is $clog2(2*CLK_DIV) bits. No wrap beyond frame end.

Optional Feature:
- Macro: AD9122_SPI_4WIRE_EN.
- Defined:
  - Read data is sampled from spi_sdo_i.
  - spi_sdio_oe stays 1 for the entire frame while CSN is low.
  - spi_sdio_i is ignored.
- Undefined: 3-wire behaviour as above; spi_sdo_i is ignored.

Decomposition:
- Package ad9122_spi_pkg:
  - state encoding (one-hot, 5 bits)
  - FRAME_BITS=16
  - RW_BIT=7
  - DATA_BITS=8
- Sub-module ad9122_spi_sclk_gen:
  - phase counter, SCLK generation, one-cycle rise_stb/fall_stb outputs
  - enabled only in SHIFT

Test Plan:
- Write: write_req with addr=0x0D, data=0xD9 -> SDIO carries 0x0DD9 MSB-first on SCLK rises; oe=1 throughout; single r_w_end at cycle 136; r_ad_data unchanged.
- Read: read_req with addr=0x0A, DAC model driving 0xA5 on falling edges -> instruction on wire is 0x8A; oe falls at the bit-7 low phase; r_ad_data=0xA5 when r_w_end pulses.
- Busy/collision:
  - write_req pulsed mid-SHIFT -> ignored; only one frame.
  - write_req and read_req in the same cycle -> write frame, rw bit 0.
- Reset mid-transaction: rstn low during bit 10 -> spi_csn=1, spi_sclk=0, oe=0 on the next edge; no r_w_end ever appears.
- Back-to-back: connect the config sequencer and run its 11-write/8-read sequence -> 19 frames; each frame's wire instruction and data match the requested address/data; config_end asserts; minimum CSN-high time is CSN_IDLE.
- With AD9122_SPI_4WIRE_EN: read 0x0A, model drives 0x3C on spi_sdo_i and 0xFF on spi_sdio_i -> r_ad_data=0x3C; oe stays 1 for the whole frame.
